// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: init, auto-refresh and NCH user burst engines share one
// registered pin set. Refresh wins; users are fixed-priority or round-robin.
module sdram_cmd_arbiter #(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 12,
  parameter int BA_W    = 2,
  parameter int DQ_W    = 16,
  parameter int RR_MODE = 1,
  parameter int WDOG    = 1024,
  localparam int GID_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic [3:0]             init_cmd,
  input  logic [ADDR_W-1:0]      init_addr,
  input  logic                   aref_req,
  input  logic                   aref_end,
  input  logic [3:0]             aref_cmd,
  input  logic [ADDR_W-1:0]      aref_addr,
  output logic                   aref_en,
  input  logic [NCH-1:0]         ch_req,
  input  logic [NCH-1:0]         ch_end,
  input  logic [4*NCH-1:0]       ch_cmd,
  input  logic [ADDR_W*NCH-1:0]  ch_addr,
  input  logic [BA_W*NCH-1:0]    ch_bank,
  input  logic [DQ_W*NCH-1:0]    ch_dq,
  input  logic [NCH-1:0]         ch_dq_oe,
  output logic [NCH-1:0]         ch_en,
  output logic [3:0]             sdram_cmd,
  output logic [ADDR_W-1:0]      sdram_addr,
  output logic [BA_W-1:0]        sdram_bank,
  output logic [DQ_W-1:0]        sdram_dq_out,
  output logic                   sdram_dq_oe,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   err_timeout
);
  localparam int         WD_W = $clog2(WDOG);
  localparam logic [3:0] NOP  = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_ARBIT, S_AREF, S_GRANT} state_t;

  state_t            r_state, w_nstate;
  logic [GID_W-1:0]  r_gid, r_ptr, w_win;
  logic              w_found, w_end;
  logic [WD_W-1:0]   r_wdog;
  logic [NCH-1:0]    r_ch_en, w_ch_en;
  logic              r_aref_en, w_aref_en, r_err, w_err, r_busy;
  logic [3:0]        r_cmd, w_cmd;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [BA_W-1:0]   r_bank, w_bank;
  logic [DQ_W-1:0]   r_dq, w_dq;
  logic              r_oe, w_oe;

  // Winner search; in round-robin it starts just past the last granted channel.
  always_comb begin
    int j;
    w_win   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int i = 0; i < NCH; i++) begin
      j = (RR_MODE != 0) ? int'(r_ptr) + 1 + i : i;
      if (j >= NCH) j = j - NCH;
      if (!w_found && ch_req[j]) begin
        w_found = 1'b1;
        w_win   = GID_W'(j);
      end
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_ch_en   = '0;
    w_aref_en = 1'b0;
    w_err     = 1'b0;
    w_cmd     = NOP;
    w_addr    = '0;
    w_bank    = '0;
    w_dq      = '0;
    w_oe      = 1'b0;
    w_end     = (r_state == S_AREF) ? aref_end : ch_end[r_gid];
    case (r_state)
      S_IDLE: begin
        w_cmd  = init_cmd;
        w_addr = init_addr;
        if (init_done) w_nstate = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_req) begin
          w_nstate  = S_AREF;
          w_aref_en = 1'b1;
        end else if (w_found) begin
          w_nstate       = S_GRANT;
          w_ch_en[w_win] = 1'b1;
        end
      end
      default: begin
        if (r_state == S_AREF) begin
          w_cmd  = aref_cmd;
          w_addr = aref_addr;
        end else begin
          w_cmd  = ch_cmd[4*int'(r_gid) +: 4];
          w_addr = ch_addr[ADDR_W*int'(r_gid) +: ADDR_W];
          w_bank = ch_bank[BA_W*int'(r_gid) +: BA_W];
          w_dq   = ch_dq[DQ_W*int'(r_gid) +: DQ_W];
          w_oe   = ch_dq_oe[r_gid];
        end
        if (w_end) begin
          w_nstate = S_ARBIT;
        end else if (r_wdog == WD_W'(WDOG - 1)) begin
          w_nstate = S_ARBIT;
          w_err    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gid     <= '0;
      r_ptr     <= GID_W'(NCH - 1);
      r_wdog    <= '0;
      r_ch_en   <= '0;
      r_aref_en <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd     <= NOP;
      r_addr    <= '0;
      r_bank    <= '0;
      r_dq      <= '0;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_ch_en   <= w_ch_en;
      r_aref_en <= w_aref_en;
      r_err     <= w_err;
      r_busy    <= (w_nstate == S_AREF) || (w_nstate == S_GRANT);
      r_cmd     <= w_cmd;
      r_addr    <= w_addr;
      r_bank    <= w_bank;
      r_dq      <= w_dq;
      r_oe      <= w_oe;
      if (r_state == S_ARBIT && w_nstate == S_GRANT) begin
        r_gid <= w_win;
        r_ptr <= w_win;
      end
      // Dwell counter restarts on every state change, counts only while owned.
      if (w_nstate != r_state) r_wdog <= '0;
      else if (r_busy)         r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign aref_en      = r_aref_en;
  assign ch_en        = r_ch_en;
  assign sdram_cmd    = r_cmd;
  assign sdram_addr   = r_addr;
  assign sdram_bank   = r_bank;
  assign sdram_dq_out = r_dq;
  assign sdram_dq_oe  = r_oe;
  assign grant_id     = r_gid;
  assign busy         = r_busy;
  assign err_timeout  = r_err;
endmodule
